// File: rtl/standby_ctrl_if.sv
// Signal bundle between the standby sequencer and the core-side logic.
// The master drives the requests and wakeups, the slave is the controller.
interface standby_ctrl_if #(
    parameter int N = 5
);
    logic         sleep_req;
    logic [N-1:0] wakeup;
    logic [N-1:0] wakeup_en;
    logic         idle;
    logic         clk_en;
    logic         halt;
    logic         sleeping;
    logic         abort;
    logic [N-1:0] wake_cause;
    logic [2:0]   state;

    modport master (
        output sleep_req, wakeup, wakeup_en, idle,
        input  clk_en, halt, sleeping, abort, wake_cause, state
    );

    modport slave (
        input  sleep_req, wakeup, wakeup_en, idle,
        output clk_en, halt, sleeping, abort, wake_cause, state
    );
endinterface

// File: rtl/standby_ctrl.sv
// RUN -> DRAIN -> HOLD -> SLEEP -> WAKE -> RUN standby sequencer.
// Runs on free-running clkin and drives the core clock gate enable.
module standby_ctrl #(
    parameter int N        = 5,
    parameter int PD       = 5,
    parameter int WAKE_CYC = 2,
    parameter int DRAIN_TO = 256
) (
    input  logic          clkin,
    input  logic          nreset,
    standby_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        RUN   = 3'd0,
        DRAIN = 3'd1,
        HOLD  = 3'd2,
        SLEEP = 3'd3,
        WAKE  = 3'd4
    } state_e;

    localparam logic [15:0] PD_M1  = 16'(PD - 1);
    localparam logic [15:0] WK_M1  = 16'(WAKE_CYC - 1);
    localparam logic [15:0] DTO_M1 = 16'(DRAIN_TO - 1);

    state_e       state_q, state_d;
    logic [15:0]  drn_q, drn_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [N-1:0] wc_q, wc_d;
    logic         abort_q, abort_d;
    logic [N-1:0] wakeup_q;
    logic         sleep_q;

    logic [N-1:0] wake_vec;
    logic         wake;
    logic         sreq_rise;

    assign wake_vec  = bus.wakeup & ~wakeup_q & bus.wakeup_en;
    assign wake      = |wake_vec;
    assign sreq_rise = bus.sleep_req & ~sleep_q;

    always_ff @(posedge clkin or negedge nreset) begin
        if (!nreset) begin
            state_q  <= RUN;
            drn_q    <= '0;
            cnt_q    <= '0;
            wc_q     <= '0;
            abort_q  <= 1'b0;
            wakeup_q <= '0;
            sleep_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            drn_q    <= drn_d;
            cnt_q    <= cnt_d;
            wc_q     <= wc_d;
            abort_q  <= abort_d;
            wakeup_q <= bus.wakeup;
            sleep_q  <= bus.sleep_req;
        end
    end

    // cnt_q serves as the HOLD countdown and the WAKE countdown.
    always_comb begin
        state_d = state_q;
        drn_d   = drn_q;
        cnt_d   = cnt_q;
        wc_d    = wc_q;
        abort_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (sreq_rise) begin
                    state_d = DRAIN;
                    wc_d    = '0;
                    drn_d   = '0;
                end
            end
            DRAIN: begin
                wc_d = wc_q | wake_vec;
                if (wake) begin
                    state_d = RUN;
                end else if (bus.idle) begin
                    state_d = HOLD;
                    cnt_d   = PD_M1;
                end else if (DRAIN_TO != 0 && drn_q == DTO_M1) begin
                    state_d = RUN;
                    abort_d = 1'b1;
                end else begin
                    drn_d = drn_q + 16'd1;
                end
            end
            HOLD: begin
                wc_d = wc_q | wake_vec;
                if (wake) begin
                    state_d = RUN;
                end else if (!bus.idle) begin
                    state_d = DRAIN;
                end else if (cnt_q == 16'd0) begin
                    state_d = SLEEP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            SLEEP: begin
                wc_d = wc_q | wake_vec;
                if (wake || !bus.sleep_req) begin
                    state_d = WAKE;
                    cnt_d   = WK_M1;
                end
            end
            WAKE: begin
                if (cnt_q == 16'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign bus.clk_en     = (state_q != SLEEP);
    assign bus.halt       = (state_q != RUN);
    assign bus.sleeping   = (state_q == SLEEP);
    assign bus.abort      = abort_q;
    assign bus.wake_cause = wc_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_standby_ctrl.sv
// Directed bench for standby_ctrl: vector table plus corner sequences.
module tb_standby_ctrl;
    logic clkin = 1'b0;
    logic nreset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [4:0] wen;

    standby_ctrl_if #(.N(5)) bus ();

    standby_ctrl #(
        .N(5), .PD(5), .WAKE_CYC(2), .DRAIN_TO(16)
    ) dut (
        .clkin (clkin),
        .nreset(nreset),
        .bus   (bus.slave)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic       sreq;
        logic [4:0] wk;
        logic       idle;
        logic [2:0] st;
        logic       ce;
        logic       hl;
        logic       sl;
        logic       ab;
        logic [4:0] wc;
    } vec_t;

    vec_t tv[26];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic [4:0] w, input logic i);
        @(negedge clkin);
        bus.sleep_req = s;
        bus.wakeup    = w;
        bus.idle      = i;
        bus.wakeup_en = wen;
        @(posedge clkin);
        #1;
    endtask

    task automatic chk_st(input string nm, input logic [2:0] st,
                          input logic ce, input logic hl);
        chk({nm, ".state"}, 32'(bus.state), 32'(st));
        chk({nm, ".clk_en"}, 32'(bus.clk_en), 32'(ce));
        chk({nm, ".halt"}, 32'(bus.halt), 32'(hl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        wen = 5'b00100;
        bus.sleep_req = 1'b0;
        bus.wakeup    = 5'b0;
        bus.wakeup_en = wen;
        bus.idle      = 1'b0;

        // normal sleep/wake, then masked event and sleep_req drop in SLEEP
        tv[0]  = '{1'b1, 5'b00000, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[1]  = '{1'b1, 5'b00000, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[2]  = '{1'b1, 5'b00000, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[3]  = '{1'b1, 5'b00000, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[4]  = '{1'b1, 5'b00000, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[5]  = '{1'b1, 5'b00000, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[6]  = '{1'b1, 5'b00000, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[7]  = '{1'b1, 5'b00000, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[8]  = '{1'b1, 5'b00000, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000};
        tv[9]  = '{1'b1, 5'b00000, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000};
        tv[10] = '{1'b1, 5'b00100, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00100};
        tv[11] = '{1'b1, 5'b00100, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00100};
        tv[12] = '{1'b1, 5'b00100, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100};
        tv[13] = '{1'b0, 5'b00100, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100};
        tv[14] = '{1'b1, 5'b00100, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[15] = '{1'b1, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[16] = '{1'b1, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[17] = '{1'b1, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[18] = '{1'b1, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[19] = '{1'b1, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[20] = '{1'b1, 5'b00100, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000};
        tv[21] = '{1'b1, 5'b00101, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000};
        tv[22] = '{1'b1, 5'b00001, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000};
        tv[23] = '{1'b0, 5'b00001, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[24] = '{1'b0, 5'b00001, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000};
        tv[25] = '{1'b0, 5'b00001, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000};

        #12;
        chk_st("reset", 3'd0, 1'b1, 1'b0);
        chk("reset.sleeping", 32'(bus.sleeping), 32'd0);
        chk("reset.abort", 32'(bus.abort), 32'd0);
        chk("reset.wake_cause", 32'(bus.wake_cause), 32'd0);
        @(negedge clkin);
        nreset = 1'b1;

        for (int i = 0; i < 26; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            cyc(tv[i].sreq, tv[i].wk, tv[i].idle);
            chk_st(nm, tv[i].st, tv[i].ce, tv[i].hl);
            chk({nm, ".sleeping"}, 32'(bus.sleeping), 32'(tv[i].sl));
            chk({nm, ".abort"}, 32'(bus.abort), 32'(tv[i].ab));
            chk({nm, ".wake_cause"}, 32'(bus.wake_cause), 32'(tv[i].wc));
        end

        // idle glitch in the third HOLD cycle restarts the full hold period
        cyc(1'b0, 5'b00001, 1'b0);
        cyc(1'b1, 5'b00001, 1'b0);
        chk_st("glitch.drain", 3'd1, 1'b1, 1'b1);
        cyc(1'b1, 5'b00001, 1'b1);
        cyc(1'b1, 5'b00001, 1'b1);
        cyc(1'b1, 5'b00001, 1'b1);
        chk_st("glitch.hold3", 3'd2, 1'b1, 1'b1);
        cyc(1'b1, 5'b00001, 1'b0);
        chk_st("glitch.back", 3'd1, 1'b1, 1'b1);
        cyc(1'b1, 5'b00001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 5'b00001, 1'b1);
            chk_st($sformatf("glitch.rehold%0d", i), 3'd2, 1'b1, 1'b1);
        end
        cyc(1'b1, 5'b00001, 1'b1);
        chk_st("glitch.sleep", 3'd3, 1'b0, 1'b1);
        cyc(1'b0, 5'b00001, 1'b1);
        cyc(1'b0, 5'b00001, 1'b1);
        cyc(1'b0, 5'b00001, 1'b1);
        chk_st("glitch.run", 3'd0, 1'b1, 1'b0);

        // drain timeout after 16 cycles, no re-entry while level high
        cyc(1'b1, 5'b00001, 1'b0);
        chk_st("to.enter", 3'd1, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, 5'b00001, 1'b0);
            chk($sformatf("to.drain%0d.state", i), 32'(bus.state), 32'd1);
            chk($sformatf("to.drain%0d.abort", i), 32'(bus.abort), 32'd0);
        end
        cyc(1'b1, 5'b00001, 1'b0);
        chk_st("to.exit", 3'd0, 1'b1, 1'b0);
        chk("to.abort", 32'(bus.abort), 32'd1);
        cyc(1'b1, 5'b00001, 1'b0);
        chk("to.abort_clr", 32'(bus.abort), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 5'b00001, 1'b0);
            chk_st($sformatf("to.rearm%0d", i), 3'd0, 1'b1, 1'b0);
        end

        // wakeup edge coincides with hold expiry
        cyc(1'b0, 5'b00001, 1'b0);
        cyc(1'b1, 5'b00001, 1'b0);
        cyc(1'b1, 5'b00001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 5'b00001, 1'b1);
            chk($sformatf("race.clk_en%0d", i), 32'(bus.clk_en), 32'd1);
        end
        cyc(1'b1, 5'b00101, 1'b1);
        chk_st("race.run", 3'd0, 1'b1, 1'b0);
        chk("race.wake_cause", 32'(bus.wake_cause), 32'b00100);
        cyc(1'b1, 5'b00101, 1'b1);
        chk_st("race.stay", 3'd0, 1'b1, 1'b0);

        // asynchronous reset while sleeping
        cyc(1'b0, 5'b00101, 1'b0);
        cyc(1'b1, 5'b00101, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 5'b00101, 1'b1);
        chk_st("rst.sleep", 3'd3, 1'b0, 1'b1);
        @(negedge clkin);
        #2;
        nreset = 1'b0;
        #1;
        chk_st("rst.async", 3'd0, 1'b1, 1'b0);
        chk("rst.sleeping", 32'(bus.sleeping), 32'd0);
        chk("rst.wake_cause", 32'(bus.wake_cause), 32'd0);
        bus.sleep_req = 1'b0;
        @(negedge clkin);
        nreset = 1'b1;
        cyc(1'b0, 5'b00101, 1'b1);
        chk_st("rst.after", 3'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/standby_ctrl.md
Name: standby_ctrl

Overview:
- Sequencer that takes a core from RUN into clock-gated SLEEP and back again, and drives the enable input of the core's clock gating cell.
- Handshake steps:
  - halts the core on a sleep request;
  - waits for the core to report idle and confirms idle is stable for a hold period;
  - gates the clock;
  - on a masked wakeup event, re-enables the clock and holds the core for a settle period before releasing it.
- The controller itself runs on free-running clkin, outside the gated domain.

Parameters:
N, 5, width of wakeup event vector
PD, 5, cycles idle must stay high in HOLD before gating (1..65535)
WAKE_CYC, 2, cycles clock runs with core halted after wakeup (1..65535)
DRAIN_TO, 256, max cycles spent draining before abort; 0 = no timeout (0..65535)

Ports:
clkin  input  1  free-running clock
nreset  input  1  asynchronous active-low reset
sleep_req  input  1  level sleep request; only a rising edge starts a sleep sequence
wakeup  input  N  wakeup events, synchronous to clkin; rising edge = event
wakeup_en  input  N  per-bit event enable (1 = enabled)
idle  input  1  core reports idle
clk_en  output  1  enable to clock gating cell
halt  output  1  core stall request
sleeping  output  1  high while clock is gated
abort  output  1  one-cycle pulse on drain timeout
wake_cause  output  N  enabled wakeup events accumulated during the last sleep attempt
state  output  3  current FSM state (debug)

Behaviour:
- Reset: nreset, asynchronous, active-low; clock clkin.
  - State = RUN; all internal registers cleared.
  - Reset output values: clk_en=1, halt=0, sleeping=0, abort=0, wake_cause=0.
- Edge detection:
  - wakeup_q and sleep_q are registered copies of wakeup and sleep_req (reset value 0).
  - wake = |(wakeup & ~wakeup_q & wakeup_en).
  - sreq_rise = sleep_req & ~sleep_q.
- State encoding: RUN=0, DRAIN=1, HOLD=2, SLEEP=3, WAKE=4. Codes 5–7 recover to RUN on the next cycle.
- Outputs are decoded from the state register only (registered):
  - clk_en = (state != SLEEP).
  - halt = (state != RUN).
  - sleeping = (state == SLEEP).
- RUN:
  - sreq_rise -> DRAIN.
  - On that transition, clear wake_cause and clear the drain counter.
- DRAIN (transitions in priority order):
  - wake -> RUN.
  - idle=1 -> HOLD; hold counter loaded with PD-1.
  - DRAIN_TO!=0 and drain counter == DRAIN_TO-1 -> RUN, with abort=1 for exactly the next cycle.
  - Otherwise the drain counter increments.
  - DRAIN therefore lasts at most DRAIN_TO cycles.
- HOLD (transitions in priority order):
  - wake -> RUN.
  - idle=0 -> DRAIN; the drain counter is not cleared.
  - Hold counter == 0 -> SLEEP.
  - Otherwise the hold counter decrements.
  - With idle steady, HOLD lasts exactly PD cycles.
- SLEEP:
  - wake or sleep_req=0 -> WAKE; WAKE counter loaded with WAKE_CYC-1.
- WAKE:
  - Counter == 0 -> RUN; otherwise decrement.
  - WAKE lasts exactly WAKE_CYC cycles with clk_en=1 and halt=1.
- wake_cause:
  - In DRAIN, HOLD and SLEEP, ORs in each cycle's enabled rising edges.
  - Holds its value in RUN and WAKE.
- Simultaneous events:
  - wake takes priority over idle, hold expiry and timeout.
  - sreq_rise in any state other than RUN is ignored.
- Re-arm: a level-high sleep_req after returning to RUN does not re-enter DRAIN; a new rising edge is required.
- Latency:
  - sreq_rise at cycle t -> halt=1 at t+1.
  - idle first seen high at cycle u in DRAIN -> clk_en=0 at u+1+PD.
  - Wake edge at cycle w in SLEEP -> clk_en=1 at w+1, halt=0 at w+1+WAKE_CYC.
- Counters are 16 bits.
- Asserting reset mid-sequence (any state) returns to RUN immediately, with clk_en=1 asynchronously.

Test Plan:
- Normal sleep, PD=5, WAKE_CYC=2, idle high 3 cycles after halt:
  - Check: halt rises 1 cycle after the sleep_req edge.
  - Check: clk_en=0 exactly 6 cycles after idle is first seen.
  - Apply wakeup[2] edge with wakeup_en=5'b00100.
  - Check: clk_en=1 next cycle, halt=0 2 cycles later, wake_cause=5'b00100.
- Masked event: wakeup[0] edge with wakeup_en[0]=0 while in SLEEP -> no state change, wake_cause unchanged, clk_en stays 0.
- Idle glitch: idle drops during HOLD cycle 3 -> returns to DRAIN; idle re-asserts -> full PD=5 cycles counted again before gating.
- Timeout: DRAIN_TO=16, idle held 0 -> abort pulses exactly 1 cycle after 16 DRAIN cycles; state RUN, halt=0, no re-entry while sleep_req stays high.
- Races:
  - wakeup edge in the same cycle as hold expiry -> RUN, clk_en never drops.
  - sleep_req deasserted in SLEEP -> WAKE then RUN, wake_cause=0.
- Reset mid-sequence: nreset low while in SLEEP -> clk_en=1 and halt=0 asynchronously, state=0, wake_cause=0.
